cv_bg_linefetch: RTL and testbench

- Per-scanline BG fetch engine for one BG screen.
- On `start`, it reads tile entries and char rows from the BG tile/char memory block and emits one scanline of 8-bit pixels as a valid/ready stream to the BG line buffer / mixer.
- It sits directly upstream of the memory block: it drives `bg_screen`, `t_addr`/`t_ren` and `c_addr`/`c_ren`, and it consumes `t_dout`, `c_dout` and the scroll/bank registers.

---
 rtl/cv_bg_linefetch_pkg.sv | 17 +
 rtl/cv_bg_linefetch_pixsel.sv | 32 +++
 rtl/cv_bg_linefetch.sv | 182 ++++++++++++++++++
 tb/tb_cv_bg_linefetch.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv_bg_linefetch_pkg.sv
// Shared definitions for the BG scanline fetch engine: geometry defaults and FSM states.
package cv_bg_linefetch_pkg;

  localparam int unsigned BG_MAP_BITS = 7;
  localparam int unsigned BG_H_PIXELS = 256;

  typedef enum logic [2:0] {
    BGF_IDLE,
    BGF_TREQ,
    BGF_TWAIT,
    BGF_CREQ,
    BGF_CWAIT,
    BGF_EMIT,
    BGF_DONE
  } bgf_state_e;

endpackage

// File: rtl/cv_bg_linefetch_pixsel.sv
// 8:1 byte selector over one fetched char row; the row and index stay frozen
// while the consumer stalls, so the presented pixel holds without extra logic.
module cv_bg_pixsel (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic [63:0] load_data_i,
  input  logic [2:0]  load_idx_i,
  input  logic        adv_i,
  output logic [7:0]  pix_o,
  output logic        last_o
);

  logic [63:0] shreg_q;
  logic [2:0]  idx_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= '0;
      idx_q   <= '0;
    end else if (load_i) begin
      shreg_q <= load_data_i;
      idx_q   <= load_idx_i;
    end else if (adv_i) begin
      idx_q   <= idx_q + 3'd1;
    end
  end

  assign pix_o  = shreg_q[{idx_q, 3'b000} +: 8];
  assign last_o = (idx_q == 3'd7);

endmodule

// File: rtl/cv_bg_linefetch.sv
// Per-scanline BG fetch engine: tile lookup, char row fetch, then a pixel
// stream with valid/ready handshake to the line buffer.
module cv_bg_linefetch
  import cv_bg_linefetch_pkg::*;
#(
  parameter int unsigned H_PIXELS = BG_H_PIXELS,
  parameter int unsigned MAP_BITS = BG_MAP_BITS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [8:0]              line_y,
  input  logic [1:0]              screen_sel,
  output logic [1:0]              bg_screen,
  output logic [2*MAP_BITS-1:0]   t_addr,
  output logic                    t_ren,
  input  logic [9:0]              t_dout,
  output logic [13:0]             c_addr,
  output logic                    c_ren,
  input  logic [63:0]             c_dout,
  input  logic [MAP_BITS+2:0]     r_bg_yoffset,
  input  logic [MAP_BITS+2:0]     r_bg_xoffset,
  input  logic [1:0]              r_bg_bank,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [8:0]              out_x,
  output logic [7:0]              out_pix,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned VW   = MAP_BITS + 3;
  localparam int unsigned CW   = 10;
  localparam logic [CW-1:0] LAST = CW'(H_PIXELS - 1);

  bgf_state_e          state_q, state_d;
  logic [MAP_BITS-1:0] tile_row_q, tile_row_d;
  logic [MAP_BITS-1:0] col_q, col_d;
  logic [2:0]          row_q, row_d;
  logic [2:0]          xfine_q, xfine_d;
  logic                bank0_q, bank0_d;
  logic [1:0]          screen_q, screen_d;
  logic [9:0]          code_q, code_d;
  logic [CW-1:0]       count_q, count_d;
  logic                first_q, first_d;

  logic [VW-1:0] vy;
  logic          ps_load, ps_adv, ps_last;
  logic [2:0]    ps_idx;
  logic [7:0]    ps_pix;
  logic          unused_bank1;

  assign unused_bank1 = r_bg_bank[1];
  assign vy           = VW'(line_y) + r_bg_yoffset;
  assign bg_screen    = screen_q;

  cv_bg_pixsel u_pixsel (
    .clk        (clk),
    .reset      (reset),
    .load_i     (ps_load),
    .load_data_i(c_dout),
    .load_idx_i (ps_idx),
    .adv_i      (ps_adv),
    .pix_o      (ps_pix),
    .last_o     (ps_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BGF_IDLE;
      tile_row_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
      xfine_q    <= '0;
      bank0_q    <= 1'b0;
      screen_q   <= '0;
      code_q     <= '0;
      count_q    <= '0;
      first_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tile_row_q <= tile_row_d;
      col_q      <= col_d;
      row_q      <= row_d;
      xfine_q    <= xfine_d;
      bank0_q    <= bank0_d;
      screen_q   <= screen_d;
      code_q     <= code_d;
      count_q    <= count_d;
      first_q    <= first_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tile_row_d = tile_row_q;
    col_d      = col_q;
    row_d      = row_q;
    xfine_d    = xfine_q;
    bank0_d    = bank0_q;
    screen_d   = screen_q;
    code_d     = code_q;
    count_d    = count_q;
    first_d    = first_q;
    t_ren      = 1'b0;
    t_addr     = '0;
    c_ren      = 1'b0;
    c_addr     = '0;
    out_valid  = 1'b0;
    out_x      = '0;
    out_pix    = '0;
    busy       = 1'b0;
    done       = 1'b0;
    ps_load    = 1'b0;
    ps_adv     = 1'b0;
    ps_idx     = '0;

    case (state_q)
      BGF_IDLE: begin
        if (start) begin
          tile_row_d = vy[VW-1:3];
          row_d      = vy[2:0];
          col_d      = r_bg_xoffset[VW-1:3];
          xfine_d    = r_bg_xoffset[2:0];
          bank0_d    = r_bg_bank[0];
          screen_d   = screen_sel;
          count_d    = '0;
          first_d    = 1'b1;
          state_d    = BGF_TREQ;
        end
      end
      BGF_TREQ: begin
        busy    = 1'b1;
        t_ren   = 1'b1;
        t_addr  = {tile_row_q, col_q};
        state_d = BGF_TWAIT;
      end
      BGF_TWAIT: begin
        busy    = 1'b1;
        code_d  = t_dout;
        state_d = BGF_CREQ;
      end
      BGF_CREQ: begin
        busy    = 1'b1;
        c_ren   = 1'b1;
        c_addr  = {bank0_q, code_q, row_q};
        state_d = BGF_CWAIT;
      end
      BGF_CWAIT: begin
        busy    = 1'b1;
        ps_load = 1'b1;
        ps_idx  = first_q ? xfine_q : 3'd0;
        first_d = 1'b0;
        state_d = BGF_EMIT;
      end
      BGF_EMIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_x     = count_q[8:0];
        out_pix   = ps_pix;
        if (out_ready) begin
          ps_adv  = 1'b1;
          count_d = count_q + 1'b1;
          // The end-of-line check wins over the tile boundary so a partially
          // consumed final tile is simply abandoned.
          if (count_q == LAST) begin
            state_d = BGF_DONE;
          end else if (ps_last) begin
            col_d   = col_q + 1'b1;
            state_d = BGF_TREQ;
          end
        end
      end
      BGF_DONE: begin
        done    = 1'b1;
        state_d = BGF_IDLE;
      end
      default: state_d = BGF_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cv_bg_linefetch.sv
// Directed bench for cv_bg_linefetch with a 1-cycle-latency tile/char memory model.
module tb_cv_bg_linefetch;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [8:0]  line_y;
  logic [1:0]  screen_sel, bg_screen;
  logic [13:0] t_addr;
  logic        t_ren;
  logic [9:0]  t_dout;
  logic [13:0] c_addr;
  logic        c_ren;
  logic [63:0] c_dout;
  logic [9:0]  r_bg_yoffset, r_bg_xoffset;
  logic [1:0]  r_bg_bank;
  logic        out_valid, out_ready;
  logic [8:0]  out_x;
  logic [7:0]  out_pix;
  logic        busy, done;

  int n_cmp = 0;
  int n_bad = 0;
  int map_mode = 0;

  int t_cnt, c_cnt, done_cnt, overlap, pix_n, stall_reads, busy_at_done;
  logic [13:0] taddr_log [0:63];
  logic [13:0] caddr_log [0:63];
  logic [7:0]  cap_pix   [0:511];
  logic [8:0]  cap_x     [0:511];

  always #5 clk = ~clk;

  cv_bg_linefetch #(.H_PIXELS(256), .MAP_BITS(7)) dut (
    .clk(clk), .reset(reset), .start(start), .line_y(line_y),
    .screen_sel(screen_sel), .bg_screen(bg_screen),
    .t_addr(t_addr), .t_ren(t_ren), .t_dout(t_dout),
    .c_addr(c_addr), .c_ren(c_ren), .c_dout(c_dout),
    .r_bg_yoffset(r_bg_yoffset), .r_bg_xoffset(r_bg_xoffset), .r_bg_bank(r_bg_bank),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_pix(out_pix),
    .busy(busy), .done(done)
  );

  function automatic logic [7:0] char_byte(input logic bank, input logic [9:0] code,
                                           input logic [2:0] row, input int p);
    int v;
    v = p + 1 + 9 * int'(row) + 37 * (int'(code) - 1) + 101 * int'(bank);
    return v[7:0];
  endfunction

  function automatic logic [9:0] tile_code(input logic [13:0] a);
    return (map_mode != 0) ? a[9:0] : 10'd1;
  endfunction

  function automatic logic [63:0] char_line(input logic [13:0] a);
    logic [63:0] l;
    for (int p = 0; p < 8; p++) l[p*8 +: 8] = char_byte(a[13], a[12:3], a[2:0], p);
    return l;
  endfunction

  function automatic logic [7:0] exp_pix(input int x);
    int vy, px, col, code_i;
    logic [31:0] cv;
    vy = (int'(line_y) + int'(r_bg_yoffset)) % 1024;
    px = (int'(r_bg_xoffset) + x) % 1024;
    col = (px >> 3) & 127;
    code_i = (map_mode != 0) ? ((((vy >> 3) & 7) << 7) | col) : 1;
    cv = code_i;
    return char_byte(r_bg_bank[0], cv[9:0], 3'(vy & 7), px & 7);
  endfunction

  always @(posedge clk) begin
    if (t_ren) t_dout <= tile_code(t_addr);
    if (c_ren) c_dout <= char_line(c_addr);
  end

  always @(negedge clk) begin
    if (t_ren) begin
      if (t_cnt < 64) taddr_log[t_cnt] = t_addr;
      t_cnt++;
    end
    if (c_ren) begin
      if (c_cnt < 64) caddr_log[c_cnt] = c_addr;
      c_cnt++;
    end
    if (t_ren && c_ren) overlap++;
    if (done) begin
      done_cnt++;
      if (busy) busy_at_done++;
    end
    if (out_valid && !out_ready && (t_ren || c_ren)) stall_reads++;
    if (out_valid && out_ready) begin
      if (pix_n < 512) begin
        cap_pix[pix_n] = out_pix;
        cap_x[pix_n]   = out_x;
      end
      pix_n++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    t_cnt = 0; c_cnt = 0; done_cnt = 0; overlap = 0; pix_n = 0;
    stall_reads = 0; busy_at_done = 0;
    for (int i = 0; i < 512; i++) begin
      cap_pix[i] = 'x;
      cap_x[i]   = 'x;
    end
    for (int i = 0; i < 64; i++) begin
      taddr_log[i] = 'x;
      caddr_log[i] = 'x;
    end
  endtask

  task automatic start_line(input logic [8:0] y, input logic [1:0] sel);
    line_y = y;
    screen_sel = sel;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (done_cnt == 0 && k < 4000) begin
      tick();
      k++;
    end
    n_cmp++;
    if (done_cnt == 0) begin
      n_bad++;
      $display("FAIL %s_timeout: no done after %0d cycles, required done", name, k);
    end
    tick();
    tick();
  endtask

  task automatic check_line(input string name, input int tiles);
    n_cmp++;
    if (pix_n !== 256) begin n_bad++; $display("FAIL %s_pixcount: got %0d want 256", name, pix_n); end
    n_cmp++;
    if (t_cnt !== tiles) begin n_bad++; $display("FAIL %s_treads: got %0d want %0d", name, t_cnt, tiles); end
    n_cmp++;
    if (c_cnt !== tiles) begin n_bad++; $display("FAIL %s_creads: got %0d want %0d", name, c_cnt, tiles); end
    n_cmp++;
    if (done_cnt !== 1) begin n_bad++; $display("FAIL %s_done: got %0d pulses want 1", name, done_cnt); end
    n_cmp++;
    if (overlap !== 0) begin n_bad++; $display("FAIL %s_overlap: got %0d want 0", name, overlap); end
    n_cmp++;
    if (busy_at_done !== 0) begin n_bad++; $display("FAIL %s_busy_done: got %0d want 0", name, busy_at_done); end
    for (int i = 0; i < 256; i++) begin
      n_cmp++;
      if (cap_x[i] !== 9'(i) || cap_pix[i] !== exp_pix(i)) begin
        n_bad++;
        $display("FAIL %s_pix[%0d]: got x=%0d pix=%02h want x=%0d pix=%02h",
                 name, i, cap_x[i], cap_pix[i], i, exp_pix(i));
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; out_ready = 1'b1; line_y = '0; screen_sel = '0;
    r_bg_xoffset = '0; r_bg_yoffset = '0; r_bg_bank = '0; map_mode = 0;
    clear_mon();
    repeat (3) tick();
    reset = 1'b0;
    tick();
    n_cmp++;
    if ({out_valid, busy, done, t_ren, c_ren, bg_screen, out_x, out_pix, t_addr, c_addr} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got v=%b b=%b d=%b tr=%b cr=%b s=%0d x=%0d p=%0d ta=%h ca=%h want all 0",
               out_valid, busy, done, t_ren, c_ren, bg_screen, out_x, out_pix, t_addr, c_addr);
    end
  endtask

  task automatic test_basic();
    map_mode = 0; r_bg_xoffset = 10'd0; r_bg_yoffset = 10'd0; r_bg_bank = 2'd0;
    clear_mon();
    start_line(9'd0, 2'd0);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b want 1", busy); end
    wait_done("basic");
    check_line("basic", 32);
    n_cmp++;
    if (cap_pix[0] !== 8'h01 || cap_pix[7] !== 8'h08 || cap_pix[8] !== 8'h01 || cap_pix[255] !== 8'h08) begin
      n_bad++;
      $display("FAIL basic_pattern: got %02h %02h %02h %02h want 01 08 01 08",
               cap_pix[0], cap_pix[7], cap_pix[8], cap_pix[255]);
    end
  endtask

  task automatic test_xfine();
    map_mode = 0; r_bg_xoffset = 10'd3; r_bg_yoffset = 10'd0; r_bg_bank = 2'd0;
    clear_mon();
    start_line(9'd0, 2'd0);
    wait_done("xfine");
    check_line("xfine", 33);
    n_cmp++;
    if (cap_pix[0] !== 8'h04 || cap_pix[255] !== 8'h03 || taddr_log[32] !== 14'd32) begin
      n_bad++;
      $display("FAIL xfine_edges: got first=%02h last=%02h ta32=%h want 04 03 0020",
               cap_pix[0], cap_pix[255], taddr_log[32]);
    end
  endtask

  task automatic test_wrap();
    map_mode = 1; r_bg_xoffset = 10'd1020; r_bg_yoffset = 10'd1020; r_bg_bank = 2'b11;
    clear_mon();
    start_line(9'd5, 2'd1);
    wait_done("wrap");
    check_line("wrap", 33);
    n_cmp++;
    if (taddr_log[0] !== 14'h007F || taddr_log[1] !== 14'h0000 || taddr_log[32] !== 14'h001F) begin
      n_bad++;
      $display("FAIL wrap_taddr: got %h %h %h want 007f 0000 001f", taddr_log[0], taddr_log[1], taddr_log[32]);
    end
    n_cmp++;
    if (caddr_log[0] !== 14'h23F9 || caddr_log[1] !== 14'h2001) begin
      n_bad++;
      $display("FAIL wrap_caddr: got %h %h want 23f9 2001", caddr_log[0], caddr_log[1]);
    end
    n_cmp++;
    if (cap_pix[0] !== 8'hA9) begin n_bad++; $display("FAIL wrap_first_pix: got %02h want a9", cap_pix[0]); end
  endtask

  task automatic test_stall();
    int k;
    map_mode = 0; r_bg_xoffset = 10'd0; r_bg_yoffset = 10'd0; r_bg_bank = 2'd0;
    clear_mon();
    start_line(9'd0, 2'd0);
    k = 0;
    while (!(out_valid && out_x == 9'd10) && k < 500) begin tick(); k++; end
    n_cmp++;
    if (!(out_valid && out_x == 9'd10)) begin n_bad++; $display("FAIL stall_reach: got x=%0d want 10", out_x); end
    out_ready = 1'b0;
    n_cmp++;
    if (out_pix !== 8'h03) begin n_bad++; $display("FAIL stall_pix0: got %02h want 03", out_pix); end
    for (int c = 1; c < 3; c++) begin
      tick();
      if (c == 2) out_ready = 1'b1;
      n_cmp++;
      if (!out_valid || out_x !== 9'd10 || out_pix !== 8'h03 || t_ren || c_ren) begin
        n_bad++;
        $display("FAIL stall_hold%0d: got v=%b x=%0d p=%02h tr=%b cr=%b want 1 10 03 0 0",
                 c, out_valid, out_x, out_pix, t_ren, c_ren);
      end
    end
    tick();
    n_cmp++;
    if (out_x !== 9'd11) begin n_bad++; $display("FAIL stall_release: got x=%0d want 11", out_x); end
    wait_done("stall");
    check_line("stall", 32);
    n_cmp++;
    if (stall_reads !== 0) begin n_bad++; $display("FAIL stall_reads: got %0d want 0", stall_reads); end
  endtask

  task automatic test_start_ignore();
    int k;
    map_mode = 0; r_bg_xoffset = 10'd0; r_bg_yoffset = 10'd0; r_bg_bank = 2'd0;
    clear_mon();
    start_line(9'd0, 2'd0);
    repeat (20) tick();
    start_line(9'd7, 2'd3);
    n_cmp++;
    if (bg_screen !== 2'd0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL ignore_midline: got screen=%0d busy=%b want 0 1", bg_screen, busy);
    end
    line_y = 9'd0;
    k = 0;
    while (!done && k < 4000) begin tick(); k++; end
    n_cmp++;
    if (!done) begin n_bad++; $display("FAIL ignore_done_reach: got done=%b want 1", done); end
    screen_sel = 2'd1; start = 1'b1;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || bg_screen !== 2'd0) begin
      n_bad++;
      $display("FAIL ignore_on_done: got busy=%b screen=%0d want 0 0", busy, bg_screen);
    end
    screen_sel = 2'd2;
    tick();
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || bg_screen !== 2'd2) begin
      n_bad++;
      $display("FAIL ignore_accept: got busy=%b screen=%0d want 1 2", busy, bg_screen);
    end
    n_cmp++;
    if (done_cnt !== 1 || pix_n !== 256) begin
      n_bad++;
      $display("FAIL ignore_first_line: got done=%0d pix=%0d want 1 256", done_cnt, pix_n);
    end
    clear_mon();
    wait_done("second");
    check_line("second", 32);
  endtask

  task automatic test_reset_mid();
    int k;
    map_mode = 0; r_bg_xoffset = 10'd0; r_bg_yoffset = 10'd0; r_bg_bank = 2'd0;
    clear_mon();
    start_line(9'd0, 2'd3);
    k = 0;
    while (!(out_valid && out_x == 9'd40) && k < 500) begin tick(); k++; end
    reset = 1'b1;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || bg_screen !== 2'd0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_outputs: got v=%b b=%b s=%0d d=%b want 0 0 0 0", out_valid, busy, bg_screen, done);
    end
    reset = 1'b0;
    clear_mon();
    repeat (10) tick();
    n_cmp++;
    if (done_cnt !== 0 || t_cnt !== 0) begin
      n_bad++;
      $display("FAIL rstmid_quiet: got done=%0d treads=%0d want 0 0", done_cnt, t_cnt);
    end
    clear_mon();
    start_line(9'd0, 2'd0);
    wait_done("rstmid");
    check_line("rstmid", 32);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_xfine();
    test_wrap();
    test_stall();
    test_start_ignore();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
